// File: rtl/axi_lite_rr_arbiter.sv
// axi_lite_rr_arbiter: shares one AXI4-Lite master port between NoSlvPorts
// requesters. AW and AR use independent round-robin arbitration with a
// stability lock. W/B/R are steered by fall-through index FIFOs that record
// grant order. Optional per-port stall counters are enabled with the macro
// AXI_LITE_RR_ARBITER_STALL_CNT_EN.

package axi_lite_rr_pkg;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct packed { logic [1:0] resp; } b_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_t;
  typedef struct packed {
    ax_t aw; logic aw_valid;
    w_t w; logic w_valid;
    logic b_ready;
    ax_t ar; logic ar_valid;
    logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t b; logic b_valid;
    logic ar_ready;
    r_t r; logic r_valid;
  } resp_t;
endpackage

// Fall-through index FIFO: an empty FIFO presents the pushed entry in the same
// cycle. Full is taken from the registered count only, so a pop never
// unblocks a push in the same cycle.
module axi_lite_rr_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic             full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataW-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_empty, w_write, w_read;

  assign w_empty = (r_cnt == '0);
  assign full_o  = (r_cnt == CntW'(Depth));
  assign valid_o = ~w_empty | push_i;
  assign data_o  = w_empty ? data_i : r_mem[r_rd_ptr];
  // A push that is consumed in the same cycle on an empty FIFO bypasses storage.
  assign w_write = push_i & ~(w_empty & pop_i);
  assign w_read  = pop_i & ~w_empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_write) r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_write && !w_read)      r_cnt <= r_cnt + 1'b1;
      else if (w_read && !w_write) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_write) r_mem[r_wr_ptr] <= data_i;
  end
endmodule

module axi_lite_rr_arbiter #(
  parameter int unsigned NoSlvPorts = 2,
  parameter int unsigned MaxWTxns   = 4,
  parameter int unsigned MaxRTxns   = 4,
  parameter type lite_req_t  = axi_lite_rr_pkg::req_t,
  parameter type lite_resp_t = axi_lite_rr_pkg::resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  lite_req_t  [NoSlvPorts-1:0] slv_reqs_i,
  output lite_resp_t [NoSlvPorts-1:0] slv_resps_o,
  output lite_req_t                   mst_req_o,
  input  lite_resp_t                  mst_resp_i
`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
  ,
  output logic [NoSlvPorts-1:0][15:0] stall_cnt_o
`endif
);
  localparam int unsigned IdxW = $clog2(NoSlvPorts);
  typedef logic [IdxW-1:0] idx_t;

  logic [NoSlvPorts-1:0] w_aw_req, w_ar_req;
  idx_t r_aw_ptr, r_ar_ptr, r_aw_lock_idx, r_ar_lock_idx;
  logic r_aw_lock, r_ar_lock;
  idx_t w_aw_idx, w_ar_idx, w_wf_idx, w_bf_idx, w_rf_idx;
  logic w_aw_any, w_ar_any, w_mst_aw_vld, w_mst_ar_vld, w_aw_hs, w_ar_hs;
  logic w_wf_full, w_bf_full, w_rf_full, w_wf_vld, w_bf_vld, w_rf_vld;
  logic w_w_hs, w_b_hs, w_r_hs;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NoSlvPorts - 1)) ? '0 : i + 1'b1;
  endfunction

  // First requesting port at or after ptr, wrapping modulo NoSlvPorts.
  function automatic idx_t rr_pick(input logic [NoSlvPorts-1:0] v, input idx_t ptr);
    idx_t sel   = ptr;
    idx_t k     = ptr;
    logic found = 1'b0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      if (!found && v[k]) begin
        sel   = k;
        found = 1'b1;
      end
      k = next_idx(k);
    end
    return sel;
  endfunction

  // While locked the grant is frozen; otherwise pick round-robin.
  always_comb begin
    w_aw_idx     = r_aw_lock ? r_aw_lock_idx : rr_pick(w_aw_req, r_aw_ptr);
    w_aw_any     = r_aw_lock ? w_aw_req[r_aw_lock_idx] : |w_aw_req;
    w_mst_aw_vld = w_aw_any & ~w_wf_full & ~w_bf_full & ~rst_i;
    w_aw_hs      = w_mst_aw_vld & mst_resp_i.aw_ready;
    w_ar_idx     = r_ar_lock ? r_ar_lock_idx : rr_pick(w_ar_req, r_ar_ptr);
    w_ar_any     = r_ar_lock ? w_ar_req[r_ar_lock_idx] : |w_ar_req;
    w_mst_ar_vld = w_ar_any & ~w_rf_full & ~rst_i;
    w_ar_hs      = w_mst_ar_vld & mst_resp_i.ar_ready;
  end

  // Round-robin pointers advance past the winner; lock holds a stalled grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_ptr      <= '0;
      r_ar_ptr      <= '0;
      r_aw_lock     <= 1'b0;
      r_ar_lock     <= 1'b0;
      r_aw_lock_idx <= '0;
      r_ar_lock_idx <= '0;
    end else begin
      r_aw_lock     <= w_mst_aw_vld & ~mst_resp_i.aw_ready;
      r_ar_lock     <= w_mst_ar_vld & ~mst_resp_i.ar_ready;
      r_aw_lock_idx <= w_aw_idx;
      r_ar_lock_idx <= w_ar_idx;
      if (w_aw_hs) r_aw_ptr <= next_idx(w_aw_idx);
      if (w_ar_hs) r_ar_ptr <= next_idx(w_ar_idx);
    end
  end

  axi_lite_rr_idx_fifo #(.Depth(MaxWTxns), .DataW(IdxW)) u_w_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_aw_hs), .data_i(w_aw_idx),
    .pop_i(w_w_hs), .valid_o(w_wf_vld), .data_o(w_wf_idx), .full_o(w_wf_full));

  axi_lite_rr_idx_fifo #(.Depth(MaxWTxns), .DataW(IdxW)) u_b_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_aw_hs), .data_i(w_aw_idx),
    .pop_i(w_b_hs), .valid_o(w_bf_vld), .data_o(w_bf_idx), .full_o(w_bf_full));

  axi_lite_rr_idx_fifo #(.Depth(MaxRTxns), .DataW(IdxW)) u_r_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_ar_hs), .data_i(w_ar_idx),
    .pop_i(w_r_hs), .valid_o(w_rf_vld), .data_o(w_rf_idx), .full_o(w_rf_full));

  assign w_w_hs = mst_req_o.w_valid & mst_resp_i.w_ready;
  assign w_b_hs = mst_resp_i.b_valid & mst_req_o.b_ready;
  assign w_r_hs = mst_resp_i.r_valid & mst_req_o.r_ready;

  // Shared master request: muxed from the granted or FIFO-head ports.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = slv_reqs_i[w_aw_idx].aw;
    mst_req_o.aw_valid = w_mst_aw_vld;
    mst_req_o.w        = slv_reqs_i[w_wf_idx].w;
    mst_req_o.w_valid  = w_wf_vld & slv_reqs_i[w_wf_idx].w_valid;
    mst_req_o.b_ready  = w_bf_vld & slv_reqs_i[w_bf_idx].b_ready;
    mst_req_o.ar       = slv_reqs_i[w_ar_idx].ar;
    mst_req_o.ar_valid = w_mst_ar_vld;
    mst_req_o.r_ready  = w_rf_vld & slv_reqs_i[w_rf_idx].r_ready;
  end

`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  for (genvar g = 0; g < NoSlvPorts; g++) begin : g_port
    lite_resp_t w_resp;
    assign w_aw_req[g]    = slv_reqs_i[g].aw_valid;
    assign w_ar_req[g]    = slv_reqs_i[g].ar_valid;
    assign slv_resps_o[g] = w_resp;

    // Per-port response: handshakes only to the selected port, payloads broadcast.
    always_comb begin
      w_resp          = '0;
      w_resp.b        = mst_resp_i.b;
      w_resp.r        = mst_resp_i.r;
      w_resp.aw_ready = w_aw_hs && (w_aw_idx == idx_t'(g));
      w_resp.ar_ready = w_ar_hs && (w_ar_idx == idx_t'(g));
      w_resp.w_ready  = w_wf_vld && (w_wf_idx == idx_t'(g)) && mst_resp_i.w_ready;
      w_resp.b_valid  = w_bf_vld && (w_bf_idx == idx_t'(g)) && mst_resp_i.b_valid;
      w_resp.r_valid  = w_rf_vld && (w_rf_idx == idx_t'(g)) && mst_resp_i.r_valid;
    end

`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    // Count cycles where this port waits on AW or AR without a handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_stall_cnt <= '0;
      else if ((slv_reqs_i[g].aw_valid & ~w_resp.aw_ready) |
               (slv_reqs_i[g].ar_valid & ~w_resp.ar_ready))
        r_stall_cnt <= sat_inc16(r_stall_cnt);
    end
    assign stall_cnt_o[g] = r_stall_cnt;
`endif
  end
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with two requester ports.
module tb_axi_lite_rr_arbiter;
  import axi_lite_rr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  req_t  [1:0] reqs;
  resp_t [1:0] resps;
  req_t        mreq;
  resp_t       mresp;
`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
  logic [1:0][15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_lite_rr_arbiter #(.NoSlvPorts(2), .MaxWTxns(4), .MaxRTxns(4)) dut (
    .clk_i(clk), .rst_i(rst), .slv_reqs_i(reqs), .slv_resps_o(resps),
    .mst_req_o(mreq), .mst_resp_i(mresp)
`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_w;
  logic [31:0] r_data [3];

  initial begin
    rst   = 1'b1;
    reqs  = '0;
    mresp = '0;
    step();
    step();
    // requests during reset must not leak through
    reqs[0].aw_valid = 1'b1; reqs[0].ar_valid = 1'b1;
    mresp.aw_ready = 1'b1; mresp.ar_ready = 1'b1;
    #1;
    check_val("rst_mst_aw_valid", mreq.aw_valid, 1'b0);
    check_val("rst_mst_ar_valid", mreq.ar_valid, 1'b0);
    check_val("rst_aw_ready0", resps[0].aw_ready, 1'b0);
    check_val("rst_ar_ready0", resps[0].ar_ready, 1'b0);
    reqs = '0; mresp = '0;
    rst = 1'b0;
    step();

    // fairness: both ports request continuously
    reqs[0].aw.addr = 32'h100; reqs[0].aw_valid = 1'b1;
    reqs[1].aw.addr = 32'h200; reqs[1].aw_valid = 1'b1;
    mresp.aw_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("rr_aw_addr", mreq.aw.addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      check_val("rr_aw_ready0", resps[0].aw_ready, (k % 2 == 0));
      check_val("rr_aw_ready1", resps[1].aw_ready, (k % 2 == 1));
      step();
    end
    // four outstanding: fifth AW blocked
    #1;
    check_val("full_mst_aw_valid", mreq.aw_valid, 1'b0);
    check_val("full_aw_ready0", resps[0].aw_ready, 1'b0);

    // drain W in grant order 0,1,0,1
    reqs[0].w.data = 32'hD0; reqs[0].w_valid = 1'b1;
    reqs[1].w.data = 32'hD1; reqs[1].w_valid = 1'b1;
    mresp.w_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_w = (k % 2 == 0) ? 32'hD0 : 32'hD1;
      check_val("w_data", mreq.w.data, exp_w);
      check_val("w_valid", mreq.w_valid, 1'b1);
      check_val("w_ready0", resps[0].w_ready, (k % 2 == 0));
      check_val("w_ready1", resps[1].w_ready, (k % 2 == 1));
      step();
    end
    #1;
    check_val("w_empty_valid", mreq.w_valid, 1'b0);
    check_val("w_empty_ready0", resps[0].w_ready, 1'b0);
    check_val("w_empty_ready1", resps[1].w_ready, 1'b0);
    check_val("bfull_aw_valid", mreq.aw_valid, 1'b0);
    reqs[0].w_valid = 1'b0; reqs[1].w_valid = 1'b0;

    // one B returned: AW stays blocked this cycle, accepted next
    reqs[0].b_ready = 1'b1; reqs[1].b_ready = 1'b1;
    mresp.b_valid = 1'b1;
    #1;
    check_val("b0_valid0", resps[0].b_valid, 1'b1);
    check_val("b0_valid1", resps[1].b_valid, 1'b0);
    check_val("b0_mst_ready", mreq.b_ready, 1'b1);
    check_val("pop_no_unblock", mreq.aw_valid, 1'b0);
    step();
    mresp.b_valid = 1'b0;
    #1;
    check_val("unblock_aw_valid", mreq.aw_valid, 1'b1);
    check_val("unblock_aw_ready0", resps[0].aw_ready, 1'b1);
    check_val("unblock_aw_addr", mreq.aw.addr, 32'h100);
    step();
    reqs[0].aw_valid = 1'b0; reqs[1].aw_valid = 1'b0;

    // remaining B order: 1,0,1,0
    mresp.b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_val("b_order_valid1", resps[1].b_valid, (k % 2 == 0));
      check_val("b_order_valid0", resps[0].b_valid, (k % 2 == 1));
      step();
    end
    #1;
    check_val("b_empty_mst_ready", mreq.b_ready, 1'b0);
    check_val("b_empty_valid0", resps[0].b_valid, 1'b0);
    check_val("b_empty_valid1", resps[1].b_valid, 1'b0);
    mresp.b_valid = 1'b0;
    reqs[0].w_valid = 1'b1;
    #1;
    check_val("w5_valid", mreq.w_valid, 1'b1);
    check_val("w5_data", mreq.w.data, 32'hD0);
    step();
    reqs[0].w_valid = 1'b0;

    // lock: pointer now at port 1, port 0 stalled, port 1 arrives later
    mresp.aw_ready = 1'b0;
    reqs[0].aw.addr = 32'h300; reqs[0].aw_valid = 1'b1;
    #1;
    check_val("lock_c1_addr", mreq.aw.addr, 32'h300);
    check_val("lock_c1_valid", mreq.aw_valid, 1'b1);
    step();
    reqs[1].aw.addr = 32'h400; reqs[1].aw_valid = 1'b1;
    #1;
    check_val("lock_c2_addr", mreq.aw.addr, 32'h300);
    check_val("lock_c2_ready1", resps[1].aw_ready, 1'b0);
    step();
    #1;
    check_val("lock_c3_addr", mreq.aw.addr, 32'h300);
    step();
    mresp.aw_ready = 1'b1;
    #1;
    check_val("lock_hs_addr", mreq.aw.addr, 32'h300);
    check_val("lock_hs_ready0", resps[0].aw_ready, 1'b1);
    check_val("lock_hs_ready1", resps[1].aw_ready, 1'b0);
    step();
    reqs[0].aw_valid = 1'b0;
    #1;
    check_val("lock_next_addr", mreq.aw.addr, 32'h400);
    check_val("lock_next_ready1", resps[1].aw_ready, 1'b1);
    step();
    reqs[1].aw_valid = 1'b0;

    // reset with two writes outstanding (heads are port 0)
    reqs[0].w.data = 32'hE0; reqs[0].w_valid = 1'b1;
    mresp.b_valid = 1'b1;
    #1;
    check_val("pre_rst_w_valid", mreq.w_valid, 1'b1);
    check_val("pre_rst_b_valid0", resps[0].b_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_val("async_rst_w_valid", mreq.w_valid, 1'b0);
    check_val("async_rst_w_ready0", resps[0].w_ready, 1'b0);
    check_val("async_rst_b_valid0", resps[0].b_valid, 1'b0);
    check_val("async_rst_b_ready", mreq.b_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_val("post_rst_b_ready", mreq.b_ready, 1'b0);
    check_val("post_rst_b_valid0", resps[0].b_valid, 1'b0);
    check_val("post_rst_w_valid", mreq.w_valid, 1'b0);
    mresp.b_valid = 1'b0;
    reqs[0].b_ready = 1'b0; reqs[1].b_ready = 1'b0;
    reqs[1].aw.addr = 32'h500; reqs[1].aw_valid = 1'b1;
    reqs[0].aw.addr = 32'h600; reqs[0].aw_valid = 1'b1;
    #1;
    check_val("post_rst_grant_addr", mreq.aw.addr, 32'h600);
    check_val("post_rst_ready0", resps[0].aw_ready, 1'b1);
    check_val("post_rst_ready1", resps[1].aw_ready, 1'b0);
    check_val("ft_w_valid", mreq.w_valid, 1'b1);
    check_val("ft_w_data", mreq.w.data, 32'hE0);
    check_val("ft_w_ready0", resps[0].w_ready, 1'b1);
    step();
    reqs[0].aw_valid = 1'b0; reqs[1].aw_valid = 1'b0; reqs[0].w_valid = 1'b0;

    // read ordering: ports 1,0,1
    mresp.ar_ready = 1'b1;
    reqs[1].ar.addr = 32'h10; reqs[1].ar_valid = 1'b1;
    #1;
    check_val("ar1_addr", mreq.ar.addr, 32'h10);
    check_val("ar1_ready1", resps[1].ar_ready, 1'b1);
    step();
    reqs[1].ar_valid = 1'b0;
    reqs[0].ar.addr = 32'h20; reqs[0].ar_valid = 1'b1;
    #1;
    check_val("ar2_addr", mreq.ar.addr, 32'h20);
    check_val("ar2_ready0", resps[0].ar_ready, 1'b1);
    step();
    reqs[0].ar_valid = 1'b0;
    reqs[1].ar.addr = 32'h30; reqs[1].ar_valid = 1'b1;
    #1;
    check_val("ar3_addr", mreq.ar.addr, 32'h30);
    check_val("ar3_ready1", resps[1].ar_ready, 1'b1);
    step();
    reqs[1].ar_valid = 1'b0;
    r_data[0] = 32'hA; r_data[1] = 32'hB; r_data[2] = 32'hC;
    reqs[0].r_ready = 1'b1; reqs[1].r_ready = 1'b1;
    mresp.r_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mresp.r.data = r_data[k];
      #1;
      check_val("r_valid1", resps[1].r_valid, (k != 1));
      check_val("r_valid0", resps[0].r_valid, (k == 1));
      if (k == 1) check_val("r_data0", resps[0].r.data, r_data[k]);
      else        check_val("r_data1", resps[1].r.data, r_data[k]);
      step();
    end
    #1;
    check_val("r_empty_mst_ready", mreq.r_ready, 1'b0);
    check_val("r_empty_valid1", resps[1].r_valid, 1'b0);
    mresp.r_valid = 1'b0;

`ifdef AXI_LITE_RR_ARBITER_STALL_CNT_EN
    // stall counting and saturation on port 1 AR
    rst = 1'b1;
    step();
    reqs = '0; mresp = '0;
    rst = 1'b0;
    reqs[1].ar_valid = 1'b1;
    repeat (20) step();
    check_val("stall_cnt1_20", stall_cnt[1], 16'd20);
    check_val("stall_cnt0_0", stall_cnt[0], 16'd0);
    repeat (70000) step();
    check_val("stall_cnt1_sat", stall_cnt[1], 16'hFFFF);
    reqs[1].ar_valid = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
